multi_channel_dco: RTL and testbench

//  Multi-channel digitally controlled oscillator. Each channel is an N-bit phase accumulator

---
 rtl/dco_pkg.sv | 15 +
 rtl/dco_channel.sv | 77 +++++++
 rtl/multi_channel_dco.sv | 59 +++++
 tb/tb_multi_channel_dco.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/dco_pkg.sv
// Shared types and helpers for the multi-channel DCO.
package dco_pkg;

    // Per-channel retune state: ACTIVE has no config in flight, PENDING holds a shadow config.
    typedef enum logic {
        ACTIVE  = 1'b0,
        PENDING = 1'b1
    } dco_state_e;

    // Channel-select width; a single channel still gets a 1-bit select.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dco_channel.sv
// One DCO channel: phase accumulator, shadow config with phase-continuous apply,
// registered wrap tick and phase-offset clock output.
module dco_channel
    import dco_pkg::*;
#(
    parameter int N       = 5,
    parameter int INC_RST = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         sync_clr,
    input  logic         cfg_we,
    input  logic [N-1:0] cfg_inc,
    input  logic [N-1:0] cfg_phase,
    output logic         ready,
    output logic [N-1:0] q,
    output logic         clk_out,
    output logic         tick
);

    dco_state_e   state;
    logic [N-1:0] inc, phase, sh_inc, sh_phase;
    logic         settle;      // one-cycle hold-off after an apply before new configs are taken

    logic [N:0]   sum;
    logic         apply;
    logic [N-1:0] q_next, inc_next, phase_next, mix;

    // Next-state datapath: accumulate, decide whether a pending config lands this edge.
    always_comb begin
        sum        = {1'b0, q} + {1'b0, inc};
        apply      = (state == PENDING) && (!en || sum[N] || (inc == '0) || sync_clr);
        q_next     = sync_clr ? '0 : (en ? sum[N-1:0] : q);
        inc_next   = apply ? sh_inc   : inc;
        phase_next = apply ? sh_phase : phase;
        mix        = q_next + phase_next;
    end

    assign ready = (state == ACTIVE) && !settle;

    // Accumulator, config registers, retune FSM and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ACTIVE;
            q        <= '0;
            inc      <= N'(INC_RST);
            phase    <= '0;
            sh_inc   <= '0;
            sh_phase <= '0;
            settle   <= 1'b0;
            clk_out  <= 1'b0;
            tick     <= 1'b0;
        end else begin
            q       <= q_next;
            inc     <= inc_next;
            phase   <= phase_next;
            settle  <= apply;
            tick    <= en && !sync_clr && sum[N];
            clk_out <= mix[N-1];
            case (state)
                ACTIVE: begin
                    if (cfg_we) begin
                        state    <= PENDING;
                        sh_inc   <= cfg_inc;
                        sh_phase <= cfg_phase;
                    end
                end
                PENDING: begin
                    if (apply) state <= ACTIVE;
                end
                default: state <= ACTIVE;
            endcase
        end
    end

endmodule

// File: rtl/multi_channel_dco.sv
// Multi-channel DCO top: config decode / ready mux around an array of channels.
module multi_channel_dco
    import dco_pkg::*;
#(
    parameter  int N       = 5,
    parameter  int NUM_CH  = 2,
    parameter  int INC_RST = 8,
    localparam int CH_W    = ch_w(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        en,
    input  logic                     sync_clr,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [CH_W-1:0]          cfg_ch,
    input  logic [N-1:0]             cfg_inc,
    input  logic [N-1:0]             cfg_phase,
    output logic [NUM_CH-1:0][N-1:0] Q,
    output logic [NUM_CH-1:0]        clk_out,
    output logic [NUM_CH-1:0]        tick
);

    logic [NUM_CH-1:0] ch_ready, ch_we;

    // Ready mux; selects beyond the last channel are always accepted and dropped.
    always_comb begin
        cfg_ready = 1'b1;
        for (int c = 0; c < NUM_CH; c++)
            if (cfg_ch == CH_W'(c)) cfg_ready = ch_ready[c];
    end

    // Route an accepted config to its channel only.
    always_comb begin
        ch_we = '0;
        for (int c = 0; c < NUM_CH; c++)
            ch_we[c] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(c));
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        dco_channel #(
            .N       (N),
            .INC_RST (INC_RST)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .en        (en[c]),
            .sync_clr  (sync_clr),
            .cfg_we    (ch_we[c]),
            .cfg_inc   (cfg_inc),
            .cfg_phase (cfg_phase),
            .ready     (ch_ready[c]),
            .q         (Q[c]),
            .clk_out   (clk_out[c]),
            .tick      (tick[c])
        );
    end

endmodule

// File: tb/tb_multi_channel_dco.sv
// Bench for multi_channel_dco: vector table through a scoreboard queue, then
// hand-written sequences for slow retune and out-of-range channel select.
module tb_multi_channel_dco;

    logic            clk = 1'b0;
    logic            reset, sync_clr, cfg_valid, cfg_valid3;
    logic [1:0]      en;
    logic [2:0]      en3;
    logic [0:0]      cfg_ch;
    logic [1:0]      cfg_ch3;
    logic [4:0]      cfg_inc, cfg_phase;
    logic            cfg_ready, cfg_ready3;
    logic [1:0][4:0] Q;
    logic [2:0][4:0] Q3;
    logic [1:0]      clk_out, tick;
    logic [2:0]      clk_out3, tick3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multi_channel_dco #(.N(5), .NUM_CH(2), .INC_RST(8)) dut (
        .clk(clk), .reset(reset), .en(en), .sync_clr(sync_clr),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
        .cfg_inc(cfg_inc), .cfg_phase(cfg_phase),
        .Q(Q), .clk_out(clk_out), .tick(tick)
    );

    multi_channel_dco #(.N(5), .NUM_CH(3), .INC_RST(8)) dut3 (
        .clk(clk), .reset(reset), .en(en3), .sync_clr(sync_clr),
        .cfg_valid(cfg_valid3), .cfg_ready(cfg_ready3), .cfg_ch(cfg_ch3),
        .cfg_inc(cfg_inc), .cfg_phase(cfg_phase),
        .Q(Q3), .clk_out(clk_out3), .tick(tick3)
    );

    typedef struct {
        bit       rst;
        bit [1:0] en;
        bit       sclr;
        bit       cv;
        bit       ch;
        bit [4:0] inc, ph;
        bit       rdy;          // cfg_ready before the edge
        bit [4:0] q0, q1;       // after the edge
        bit [1:0] ck, tk;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic v(input bit rst, input int e, input bit sclr, input bit cv, input bit ch,
                     input int inc, input int ph, input bit rdy, input int q0, input int q1,
                     input int ck, input int tk);
        vec_t t;
        t.rst = rst; t.en = 2'(e); t.sclr = sclr; t.cv = cv; t.ch = ch;
        t.inc = 5'(inc); t.ph = 5'(ph); t.rdy = rdy;
        t.q0 = 5'(q0); t.q1 = 5'(q1); t.ck = 2'(ck); t.tk = 2'(tk);
        tbl.push_back(t);
    endtask

    initial begin
        vec_t e;
        reset = 1'b1; sync_clr = 1'b0; cfg_valid = 1'b0; cfg_valid3 = 1'b0;
        en = '0; en3 = '0; cfg_ch = '0; cfg_ch3 = '0; cfg_inc = '0; cfg_phase = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_q0", Q[0], 0); chk("rst_q1", Q[1], 0);
        chk("rst_clk", clk_out, 0); chk("rst_tick", tick, 0);
        chk("rst_ready0", cfg_ready, 1);
        cfg_ch = 1'b1; #1 chk("rst_ready1", cfg_ready, 1);

        //  rst en sc cv ch inc ph rdy q0 q1 ck tk
        // free run, inc 8
        v(0, 3, 0, 0, 0, 0, 0, 1,  8,  8, 0, 0);
        v(0, 3, 0, 0, 0, 0, 0, 1, 16, 16, 3, 0);
        v(0, 3, 0, 0, 0, 0, 0, 1, 24, 24, 3, 0);
        v(0, 3, 0, 0, 0, 0, 0, 1,  0,  0, 0, 3);
        v(0, 3, 0, 0, 0, 0, 0, 1,  8,  8, 0, 0);
        // ch0 retune to 4 at Q=8: waits for wrap, ready back at Q=4
        v(0, 3, 0, 1, 0, 4, 0, 1, 16, 16, 3, 0);
        v(0, 3, 0, 0, 0, 0, 0, 0, 24, 24, 3, 0);
        v(0, 3, 0, 0, 0, 0, 0, 0,  0,  0, 0, 3);
        v(0, 3, 0, 0, 0, 0, 0, 0,  4,  8, 0, 0);
        v(0, 3, 0, 0, 0, 0, 0, 1,  8, 16, 2, 0);
        v(0, 3, 0, 0, 0, 0, 0, 1, 12, 24, 2, 0);
        // ch1 phase 16: clk_out[1] becomes the inverse of clk_out[0]
        v(1, 0, 0, 0, 0, 0, 0, 1,  0,  0, 0, 0);
        v(0, 3, 0, 1, 1, 8,16, 1,  8,  8, 0, 0);
        v(0, 3, 0, 0, 1, 0, 0, 0, 16, 16, 3, 0);
        v(0, 3, 0, 0, 1, 0, 0, 0, 24, 24, 3, 0);
        v(0, 3, 0, 0, 1, 0, 0, 0,  0,  0, 2, 3);
        v(0, 3, 0, 0, 1, 0, 0, 0,  8,  8, 2, 0);
        v(0, 3, 0, 0, 1, 0, 0, 1, 16, 16, 1, 0);
        v(0, 3, 0, 0, 1, 0, 0, 1, 24, 24, 1, 0);
        v(0, 3, 0, 0, 1, 0, 0, 1,  0,  0, 2, 3);
        // inc 0, then retune applies without a wrap
        v(1, 0, 0, 0, 0, 0, 0, 1,  0,  0, 0, 0);
        v(0, 3, 0, 1, 0, 0, 0, 1,  8,  8, 0, 0);
        v(0, 3, 0, 0, 0, 0, 0, 0, 16, 16, 3, 0);
        v(0, 3, 0, 0, 0, 0, 0, 0, 24, 24, 3, 0);
        v(0, 3, 0, 0, 0, 0, 0, 0,  0,  0, 0, 3);
        v(0, 3, 0, 0, 0, 0, 0, 0,  0,  8, 0, 0);
        v(0, 3, 0, 1, 0, 2, 0, 1,  0, 16, 2, 0);
        v(0, 3, 0, 0, 0, 0, 0, 0,  0, 24, 2, 0);
        v(0, 3, 0, 0, 0, 0, 0, 0,  2,  0, 0, 2);
        v(0, 3, 0, 0, 0, 0, 0, 1,  4,  8, 0, 0);
        // sync_clr while ch0 pending: clear and apply on the same edge
        v(0, 3, 0, 1, 0, 8, 0, 1,  6, 16, 2, 0);
        v(0, 3, 1, 0, 0, 0, 0, 0,  0,  0, 0, 0);
        v(0, 3, 0, 0, 0, 0, 0, 0,  8,  8, 0, 0);
        v(0, 3, 0, 0, 0, 0, 0, 1, 16, 16, 3, 0);
        // reset while pending discards the shadow config
        v(0, 3, 0, 1, 0, 4,16, 1, 24, 24, 3, 0);
        v(1, 3, 0, 0, 0, 0, 0, 0,  0,  0, 0, 0);
        v(0, 3, 0, 0, 0, 0, 0, 1,  8,  8, 0, 0);
        v(0, 3, 0, 0, 0, 0, 0, 1, 16, 16, 3, 0);
        // sync_clr together with accept: captured, applied only at the next wrap
        v(0, 3, 1, 1, 0, 4, 0, 1,  0,  0, 0, 0);
        v(0, 3, 0, 0, 0, 0, 0, 0,  8,  8, 0, 0);
        v(0, 3, 0, 0, 0, 0, 0, 0, 16, 16, 3, 0);
        v(0, 3, 0, 0, 0, 0, 0, 0, 24, 24, 3, 0);
        v(0, 3, 0, 0, 0, 0, 0, 0,  0,  0, 0, 3);
        v(0, 3, 0, 0, 0, 0, 0, 0,  4,  8, 0, 0);
        v(0, 3, 0, 0, 0, 0, 0, 1,  8, 16, 2, 0);
        // ch0 disabled: retune applies next cycle, Q holds
        v(1, 0, 0, 0, 0, 0, 0, 1,  0,  0, 0, 0);
        v(0, 2, 0, 1, 0, 1, 0, 1,  0,  8, 0, 0);
        v(0, 2, 0, 0, 0, 0, 0, 0,  0, 16, 2, 0);
        v(0, 2, 0, 0, 0, 0, 0, 0,  0, 24, 2, 0);
        v(0, 2, 0, 0, 0, 0, 0, 1,  0,  0, 0, 2);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            reset = tbl[i].rst; en = tbl[i].en; sync_clr = tbl[i].sclr;
            cfg_valid = tbl[i].cv; cfg_ch = tbl[i].ch;
            cfg_inc = tbl[i].inc; cfg_phase = tbl[i].ph;
            sb.push_back(tbl[i]);
            #1 chk($sformatf("v%0d_ready", i), cfg_ready, tbl[i].rdy);
            @(posedge clk); #1;
            e = sb.pop_front();
            chk($sformatf("v%0d_q0", i), Q[0], e.q0);
            chk($sformatf("v%0d_q1", i), Q[1], e.q1);
            chk($sformatf("v%0d_clk", i), clk_out, e.ck);
            chk($sformatf("v%0d_tick", i), tick, e.tk);
        end

        // re-enabled ch0 at inc 1: +1 per cycle, clk_out period 32
        @(negedge clk);
        reset = 1'b0; sync_clr = 1'b0; cfg_valid = 1'b0; en = 2'b11;
        for (int k = 1; k <= 40; k++) begin
            logic [4:0] x0, x1;
            x0 = 5'(k); x1 = 5'(8 * k);
            @(posedge clk); #1;
            chk($sformatf("slow%0d_q0", k), Q[0], x0);
            chk($sformatf("slow%0d_q1", k), Q[1], x1);
            chk($sformatf("slow%0d_clk0", k), clk_out[0], x0[4]);
            chk($sformatf("slow%0d_tick0", k), tick[0], (x0 == 0));
        end

        // three channels, select 3 is past the end: accepted and dropped
        @(negedge clk); reset = 1'b1; en = '0;
        @(negedge clk); reset = 1'b0;
        en3 = 3'b111; cfg_valid3 = 1'b1; cfg_ch3 = 2'd3; cfg_inc = 5'd1; cfg_phase = 5'd16;
        #1 chk("oor_ready", cfg_ready3, 1);
        for (int k = 1; k <= 7; k++) begin
            logic [4:0] x;
            x = 5'(8 * k);
            @(posedge clk); #1;
            for (int c = 0; c < 3; c++) begin
                chk($sformatf("oor%0d_q%0d", k, c), Q3[c], x);
                chk($sformatf("oor%0d_clk%0d", k, c), clk_out3[c], x[4]);
            end
            @(negedge clk);
            cfg_valid3 = 1'b0;
            for (int c = 0; c < 3; c++) begin
                cfg_ch3 = 2'(c);
                #1 chk($sformatf("oor%0d_ready%0d", k, c), cfg_ready3, 1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
